// File: rtl/clock_timekeeper.sv
// HH:MM:SS time-of-day sequencer: prescaled 1 Hz tick, cascaded 60/60/24 counters,
// and a RUN -> SET_HR -> SET_MIN -> RUN editing FSM driven by debounced button pulses.
module clock_timekeeper #(
  parameter int N        = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HR_MAX   = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run_en,
  input  logic         mode_btn,
  input  logic         inc_btn,
  output logic [N-1:0] sec,
  output logic [N-1:0] min,
  output logic [N-1:0] hr,
  output logic         tick,
  output logic         day_wrap,
  output logic [1:0]   mode
);

  // tick and day_wrap are single-cycle strobes with no handshake: a consumer
  // must sample them on every clock; they are never held or stretched.

  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(TICK_DIV - 1);
  localparam logic [N-1:0]    SEC_LAST = N'(SEC_MAX - 1);
  localparam logic [N-1:0]    MIN_LAST = N'(MIN_MAX - 1);
  localparam logic [N-1:0]    HR_LAST  = N'(HR_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [N-1:0]    sec_q, sec_d;
  logic [N-1:0]    min_q, min_d;
  logic [N-1:0]    hr_q, hr_d;
  logic            tick_q, tick_d;
  logic            day_wrap_q, day_wrap_d;

  logic in_run, in_set_hr, in_set_min;
  logic enter_set, leave_set;
  logic count_en, tick_ev;
  logic sec_carry, min_carry, hr_carry;
  logic hr_inc, min_inc;

  assign in_run     = (state_q == ST_RUN);
  assign in_set_hr  = (state_q == ST_SET_HR);
  assign in_set_min = (state_q == ST_SET_MIN);

  // A mode press on the RUN edge wins over a coincident seconds tick.
  assign enter_set = in_run && mode_btn;
  assign leave_set = in_set_min && mode_btn;

  assign count_en  = in_run && run_en && !mode_btn;
  assign tick_ev   = count_en && (pc_q == PC_LAST);
  assign sec_carry = tick_ev && (sec_q == SEC_LAST);
  assign min_carry = sec_carry && (min_q == MIN_LAST);
  assign hr_carry  = min_carry && (hr_q == HR_LAST);

  assign hr_inc  = in_set_hr && inc_btn && !mode_btn;
  assign min_inc = in_set_min && inc_btn && !mode_btn;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (mode_btn) state_d = ST_SET_HR;
      ST_SET_HR:  if (mode_btn) state_d = ST_SET_MIN;
      ST_SET_MIN: if (mode_btn) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (enter_set || leave_set) begin
      pc_d = '0;
    end else if (count_en) begin
      pc_d = tick_ev ? '0 : pc_q + PC_W'(1);
    end
  end

  always_comb begin
    sec_d = sec_q;
    if (enter_set) begin
      sec_d = '0;
    end else if (tick_ev) begin
      sec_d = sec_carry ? '0 : sec_q + N'(1);
    end
  end

  // Minute edits wrap locally and never carry into hours.
  always_comb begin
    min_d = min_q;
    if (min_inc) begin
      min_d = (min_q == MIN_LAST) ? '0 : min_q + N'(1);
    end else if (sec_carry) begin
      min_d = min_carry ? '0 : min_q + N'(1);
    end
  end

  always_comb begin
    hr_d = hr_q;
    if (hr_inc) begin
      hr_d = (hr_q == HR_LAST) ? '0 : hr_q + N'(1);
    end else if (min_carry) begin
      hr_d = hr_carry ? '0 : hr_q + N'(1);
    end
  end

  always_comb begin
    tick_d     = tick_ev;
    day_wrap_d = hr_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hr       = hr_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper with TICK_DIV=4: a seconds-of-day reference
// model feeds an expected-snapshot queue, plus directed checks of the key scenarios.
module tb_clock_timekeeper;

  localparam int N        = 8;
  localparam int TICK_DIV = 4;
  localparam int W        = 3 * N + 4;

  logic         clk;
  logic         rst_n;
  logic         run_en;
  logic         mode_btn;
  logic         inc_btn;
  logic [N-1:0] sec;
  logic [N-1:0] min;
  logic [N-1:0] hr;
  logic         tick;
  logic         day_wrap;
  logic [1:0]   mode;

  clock_timekeeper #(
    .N        (N),
    .TICK_DIV (TICK_DIV),
    .SEC_MAX  (60),
    .MIN_MAX  (60),
    .HR_MAX   (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .tick     (tick),
    .day_wrap (day_wrap),
    .mode     (mode)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_sec, m_min, m_hr, m_pc, m_mode, m_tick, m_dw;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int h, input int m, input int s,
                                        input int md, input int t, input int dw);
    return {N'(h), N'(m), N'(s), 2'(md), 1'(t), 1'(dw)};
  endfunction

  function automatic logic [W-1:0] dut_snap();
    return {hr, min, sec, mode, tick, day_wrap};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_pc = 0; m_mode = 0; m_tick = 0; m_dw = 0;
  endtask

  // Advance the model by one clock edge using seconds-of-day arithmetic.
  task automatic model_step(input bit run, input bit mb, input bit ib);
    int nt, ndw, total;
    nt = 0; ndw = 0;
    case (m_mode)
      0: begin
        if (mb) begin
          m_mode = 1; m_sec = 0; m_pc = 0;
        end else if (run) begin
          if (m_pc == TICK_DIV - 1) begin
            m_pc = 0; nt = 1;
            total = m_hr * 3600 + m_min * 60 + m_sec + 1;
            if (total == 24 * 3600) begin
              total = 0; ndw = 1;
            end
            m_hr  = total / 3600;
            m_min = (total / 60) % 60;
            m_sec = total % 60;
          end else begin
            m_pc = m_pc + 1;
          end
        end
      end
      1: begin
        if (mb) m_mode = 2;
        else if (ib) m_hr = (m_hr + 1) % 24;
      end
      2: begin
        if (mb) begin
          m_mode = 0; m_pc = 0;
        end else if (ib) m_min = (m_min + 1) % 60;
      end
      default: m_mode = 0;
    endcase
    m_tick = nt;
    m_dw   = ndw;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, push expectation, wait an edge, compare.
  task automatic step(input bit run, input bit mb, input bit ib);
    logic [W-1:0] exp;
    run_en   = run;
    mode_btn = mb;
    inc_btn  = ib;
    model_step(run, mb, ib);
    exp_q.push_back(pack(m_hr, m_min, m_sec, m_mode, m_tick, m_dw));
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq("snap", 32'(dut_snap()), 32'(exp));
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    run_en   = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("reset_state", 32'(dut_snap()), 32'd0);
  endtask

  task automatic set_time(input int h, input int m);
    step(0, 1, 0);
    repeat (h) step(0, 0, 1);
    step(0, 1, 0);
    repeat (m) step(0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ticks, last, cnt, waited;
    logic [N-1:0] sec_hold;

    rst_n = 1'b0; run_en = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    @(negedge clk);
    do_reset();

    // 16 running clocks: four ticks, four clocks apart, sec = 4
    ticks = 0; last = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (tick) begin
        if (ticks > 0) check_eq("tick_gap", 32'(i - last), 32'd4);
        last = i;
        ticks++;
      end
    end
    check_eq("tick_count16", 32'(ticks), 32'd4);
    check_eq("sec_after16", 32'(sec), 32'd4);

    // 23:59 preload, then 60 seconds across midnight
    set_time(23, 59);
    step(0, 1, 0);
    check_eq("preload", 32'({hr, min, sec, mode}), 32'({8'd23, 8'd59, 8'd0, 2'd0}));
    cnt = 0; ticks = 0;
    for (int i = 0; i < 60 * TICK_DIV; i++) begin
      step(1, 0, 0);
      if (day_wrap) cnt++;
      if (tick) ticks++;
    end
    check_eq("midnight_time", 32'({hr, min, sec}), 32'd0);
    check_eq("day_wrap_count", 32'(cnt), 32'd1);
    check_eq("midnight_ticks", 32'(ticks), 32'd60);

    // freeze mid-count: pc at 2 after 6 clocks, then exactly 2 clocks to the next tick
    do_reset();
    repeat (6) step(1, 0, 0);
    sec_hold = sec;
    ticks = 0;
    repeat (10) begin
      step(0, 0, 0);
      if (tick) ticks++;
    end
    check_eq("freeze_sec", 32'(sec), 32'(sec_hold));
    check_eq("freeze_ticks", 32'(ticks), 32'd0);
    waited = 0;
    while (!tick && waited < 10) begin
      step(1, 0, 0);
      waited++;
    end
    check_eq("resume_cycles", 32'(waited), 32'd2);
    check_eq("resume_sec", 32'(sec), 32'(sec_hold + 1));

    // edit sequence: 3 hour presses, 61 minute presses (wraps to 1, hr untouched)
    do_reset();
    set_time(3, 61);
    step(0, 1, 0);
    check_eq("edit_result", 32'({hr, min, sec, mode}), 32'({8'd3, 8'd1, 8'd0, 2'd0}));

    // mode and inc together in SET_HR; inc in RUN ignored
    step(0, 1, 0);
    step(0, 1, 1);
    check_eq("both_btn_mode", 32'(mode), 32'd2);
    check_eq("both_btn_hr", 32'(hr), 32'd3);
    step(0, 1, 0);
    step(1, 0, 1);
    check_eq("inc_in_run", 32'({hr, min}), 32'({8'd3, 8'd1}));

    // asynchronous reset while editing 05:07 in SET_MIN
    do_reset();
    set_time(5, 7);
    check_eq("pre_async", 32'({hr, min, mode}), 32'({8'd5, 8'd7, 2'd2}));
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", 32'(dut_snap()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();

    // constrained-random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
